// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - light code constants and transition helpers for the monitor
package traffic_light_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef struct packed {
    logic conflict;
    logic code;
    logic order;
    logic timing;
  } err_flags_t;

  function automatic logic is_onehot3(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

  function automatic logic legal_next(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == LIGHT_GREEN)  && (cur == LIGHT_YELLOW)) ||
           ((prev == LIGHT_YELLOW) && (cur == LIGHT_RED))    ||
           ((prev == LIGHT_RED)    && (cur == LIGHT_GREEN));
  endfunction

endpackage

// File: rtl/street_checker.sv
// rtl/street_checker.sv - per-street code history, dwell counter and violation pulses
module street_checker
  import traffic_light_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       code_i,
  output logic [CNT_W-1:0] dwell_o,
  output logic             onehot_o,
  output logic             code_err_o,
  output logic             order_err_o,
  output logic             timing_err_o,
  output logic             r2g_o
);

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  localparam logic [CNT_W-1:0] G_MIN     = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] Y_MIN     = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] Y_MAX     = CNT_W'(YELLOW_MAX);

  logic [2:0]       prev_code_q, prev_code_d;
  logic             prev_valid_q, prev_valid_d;
  logic             seen_green_q, seen_green_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  logic onehot, changed, checked;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_code_q  <= '0;
      prev_valid_q <= 1'b0;
      seen_green_q <= 1'b0;
      dwell_q      <= '0;
    end else begin
      prev_code_q  <= prev_code_d;
      prev_valid_q <= prev_valid_d;
      seen_green_q <= seen_green_d;
      dwell_q      <= dwell_d;
    end
  end

  always_comb begin
    onehot       = is_onehot3(code_i);
    changed      = (code_i != prev_code_q);
    // Transitions are judged only between two valid codes; invalid codes break the chain.
    checked      = onehot && prev_valid_q;
    prev_code_d  = code_i;
    prev_valid_d = onehot;
    seen_green_d = seen_green_q | (onehot && (code_i == LIGHT_GREEN));
    if (changed || !prev_valid_q) begin
      dwell_d = CNT_W'(1);
    end else if (dwell_q == DWELL_MAX) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + CNT_W'(1);
    end
  end

  always_comb begin
    code_err_o   = !onehot;
    order_err_o  = checked && changed && !legal_next(prev_code_q, code_i);
    timing_err_o = checked && (
                     (changed && (prev_code_q == LIGHT_GREEN) && (code_i == LIGHT_YELLOW) && (dwell_q < G_MIN)) ||
                     (changed && (prev_code_q == LIGHT_YELLOW) && (code_i == LIGHT_RED) && (dwell_q < Y_MIN)) ||
                     ((prev_code_q == LIGHT_YELLOW) && (dwell_q > Y_MAX)));
    // The green that follows reset is the start of the first cycle, not the end of one.
    r2g_o        = checked && changed && (prev_code_q == LIGHT_RED) &&
                   (code_i == LIGHT_GREEN) && seen_green_q;
    onehot_o     = onehot;
    dwell_o      = dwell_q;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker of a two-street light controller
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 3,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       street_a,
  input  logic [2:0]       street_b,
  input  logic             clr_err,
  output logic             err_conflict,
  output logic             err_code,
  output logic             err_order,
  output logic             err_timing,
  output logic             err_any,
  output logic [CNT_W-1:0] dwell_a,
  output logic [CNT_W-1:0] dwell_b,
  output logic [CYC_W-1:0] cycles_done
);

  logic onehot_a, onehot_b;
  logic code_err_a, code_err_b;
  logic order_err_a, order_err_b;
  logic timing_err_a, timing_err_b;
  logic r2g_a;

  err_flags_t       err_q, err_d, err_now;
  logic             err_any_q, err_any_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;

  street_checker #(
    .CNT_W(CNT_W), .GREEN_MIN(GREEN_MIN), .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)
  ) u_street_a (
    .clk_i(clk), .rst_i(rst), .code_i(street_a), .dwell_o(dwell_a), .onehot_o(onehot_a),
    .code_err_o(code_err_a), .order_err_o(order_err_a), .timing_err_o(timing_err_a),
    .r2g_o(r2g_a)
  );

  street_checker #(
    .CNT_W(CNT_W), .GREEN_MIN(GREEN_MIN), .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)
  ) u_street_b (
    .clk_i(clk), .rst_i(rst), .code_i(street_b), .dwell_o(dwell_b), .onehot_o(onehot_b),
    .code_err_o(code_err_b), .order_err_o(order_err_b), .timing_err_o(timing_err_b),
    .r2g_o()
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= '0;
      err_any_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      err_q     <= err_d;
      err_any_q <= err_any_d;
      cycles_q  <= cycles_d;
    end
  end

  always_comb begin
    err_now.conflict = onehot_a && onehot_b &&
                       (street_a != LIGHT_RED) && (street_b != LIGHT_RED);
    err_now.code     = code_err_a | code_err_b;
    err_now.order    = order_err_a | order_err_b;
    err_now.timing   = timing_err_a | timing_err_b;
    // A fresh violation outranks a clear issued in the same cycle.
    err_d     = (clr_err ? '0 : err_q) | err_now;
    err_any_d = |err_d;
    cycles_d  = cycles_q + (r2g_a ? CYC_W'(1) : CYC_W'(0));
  end

  assign err_conflict = err_q.conflict;
  assign err_code     = err_q.code;
  assign err_order    = err_q.order;
  assign err_timing   = err_q.timing;
  assign err_any      = err_any_q;
  assign cycles_done  = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;
  import traffic_light_pkg::*;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk;
  logic        rst;
  logic [2:0]  street_a, street_b;
  logic        clr_err;
  logic        err_conflict, err_code, err_order, err_timing, err_any;
  logic [7:0]  dwell_a, dwell_b;
  logic [15:0] cycles_done;
  logic        s_conflict, s_code, s_order, s_timing, s_any;
  logic [2:0]  s_dwell_a, s_dwell_b;
  logic [15:0] s_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .street_a(street_a), .street_b(street_b), .clr_err(clr_err),
    .err_conflict(err_conflict), .err_code(err_code), .err_order(err_order),
    .err_timing(err_timing), .err_any(err_any), .dwell_a(dwell_a), .dwell_b(dwell_b),
    .cycles_done(cycles_done)
  );

  traffic_light_monitor #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .street_a(street_a), .street_b(street_b), .clr_err(clr_err),
    .err_conflict(s_conflict), .err_code(s_code), .err_order(s_order),
    .err_timing(s_timing), .err_any(s_any), .dwell_a(s_dwell_a), .dwell_b(s_dwell_b),
    .cycles_done(s_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic c);
    street_a = a;
    street_b = b;
    clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    street_a = R;
    street_b = R;
    clr_err  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    n_assert++; if ({err_conflict, err_code, err_order, err_timing, err_any} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {err_conflict, err_code, err_order, err_timing, err_any}); end
    n_assert++; if ({dwell_a, dwell_b} !== 16'h0) begin
      n_fail++; $display("FAIL reset_dwell: got %h expected 0000", {dwell_a, dwell_b}); end
    n_assert++; if (cycles_done !== 16'd0) begin
      n_fail++; $display("FAIL reset_cycles: got %0d expected 0", cycles_done); end
  endtask

  task automatic test_legal_sequence();
    logic [2:0] a, b;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 14; i++) begin
        a = (i < 5) ? G : (i < 7) ? Y : R;
        b = (i < 7) ? R : (i < 12) ? G : Y;
        cyc(a, b, 1'b0);
        if (r == 0 && i < 5) begin
          n_assert++; if (dwell_a !== 8'(i + 1)) begin
            n_fail++; $display("FAIL legal_dwell_green: got %0d expected %0d", dwell_a, i + 1); end
        end
        if (r == 0 && i == 13) begin
          n_assert++; if (cycles_done !== 16'd0) begin
            n_fail++; $display("FAIL legal_cycles_first_round: got %0d expected 0", cycles_done); end
        end
        if (r == 1 && i == 0) begin
          n_assert++; if (cycles_done !== 16'd1) begin
            n_fail++; $display("FAIL legal_cycles_second_green: got %0d expected 1", cycles_done); end
        end
      end
    end
    n_assert++; if ({err_conflict, err_code, err_order, err_timing, err_any} !== 5'b0) begin
      n_fail++; $display("FAIL legal_no_errors: got %b expected 00000", {err_conflict, err_code, err_order, err_timing, err_any}); end
    n_assert++; if (cycles_done !== 16'd1) begin
      n_fail++; $display("FAIL legal_cycles_end: got %0d expected 1", cycles_done); end
  endtask

  task automatic test_conflict();
    do_reset();
    cyc(G, Y, 1'b0);
    n_assert++; if ({err_conflict, err_any} !== 2'b11) begin
      n_fail++; $display("FAIL conflict_set: got %b expected 11", {err_conflict, err_any}); end
    n_assert++; if (err_code !== 1'b0) begin
      n_fail++; $display("FAIL conflict_no_code: got %b expected 0", err_code); end
    cyc(G, R, 1'b0);
    n_assert++; if (err_conflict !== 1'b1) begin
      n_fail++; $display("FAIL conflict_sticky: got %b expected 1", err_conflict); end
    cyc(G, R, 1'b1);
    n_assert++; if (err_conflict !== 1'b0) begin
      n_fail++; $display("FAIL conflict_clear: got %b expected 0", err_conflict); end
  endtask

  task automatic test_order_code();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(G, R, 1'b0);
    n_assert++; if (err_order !== 1'b0) begin
      n_fail++; $display("FAIL order_before: got %b expected 0", err_order); end
    cyc(R, R, 1'b0);
    n_assert++; if ({err_order, err_code, err_timing} !== 3'b100) begin
      n_fail++; $display("FAIL order_g2r: got %b expected 100", {err_order, err_code, err_timing}); end
    cyc(R, R, 1'b1);
    n_assert++; if (err_any !== 1'b0) begin
      n_fail++; $display("FAIL order_clear: got %b expected 0", err_any); end
    cyc(3'b000, R, 1'b0);
    n_assert++; if ({err_code, err_order, err_conflict} !== 3'b100) begin
      n_fail++; $display("FAIL code_000_entry: got %b expected 100", {err_code, err_order, err_conflict}); end
    cyc(R, R, 1'b0);
    n_assert++; if ({err_code, err_order} !== 2'b10) begin
      n_fail++; $display("FAIL code_000_exit: got %b expected 10", {err_code, err_order}); end
  endtask

  task automatic test_timing();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(G, R, 1'b0);
    cyc(Y, R, 1'b0);
    n_assert++; if ({err_timing, err_order} !== 2'b10) begin
      n_fail++; $display("FAIL timing_short_green: got %b expected 10", {err_timing, err_order}); end
    cyc(Y, R, 1'b1);
    n_assert++; if (err_timing !== 1'b0) begin
      n_fail++; $display("FAIL timing_clear: got %b expected 0", err_timing); end
    cyc(Y, R, 1'b0);
    cyc(Y, R, 1'b0);
    n_assert++; if ({dwell_a, err_timing} !== {8'd4, 1'b0}) begin
      n_fail++; $display("FAIL timing_yellow_4: got dwell %0d flag %b expected dwell 4 flag 0", dwell_a, err_timing); end
    cyc(Y, R, 1'b0);
    n_assert++; if (err_timing !== 1'b1) begin
      n_fail++; $display("FAIL timing_yellow_overrun: got %b expected 1", err_timing); end
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    cyc(G, Y, 1'b1);
    n_assert++; if (err_conflict !== 1'b1) begin
      n_fail++; $display("FAIL set_wins_over_clear: got %b expected 1", err_conflict); end
    cyc(Y, R, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_assert++; if ({err_conflict, err_code, err_order, err_timing, err_any} !== 5'b0) begin
      n_fail++; $display("FAIL async_reset_flags: got %b expected 00000", {err_conflict, err_code, err_order, err_timing, err_any}); end
    n_assert++; if ({dwell_a, dwell_b, cycles_done} !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_counts: got %h expected 0", {dwell_a, dwell_b, cycles_done}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(G, R, 1'b0);
    n_assert++; if ({err_order, err_timing, err_any} !== 3'b000) begin
      n_fail++; $display("FAIL after_reset_first_code: got %b expected 000", {err_order, err_timing, err_any}); end
    n_assert++; if (dwell_a !== 8'd1) begin
      n_fail++; $display("FAIL after_reset_dwell: got %0d expected 1", dwell_a); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) cyc(R, R, 1'b0);
    n_assert++; if ({s_dwell_a, s_any} !== {3'd7, 1'b0}) begin
      n_fail++; $display("FAIL sat_dwell: got dwell %0d any %b expected dwell 7 any 0", s_dwell_a, s_any); end
    n_assert++; if (dwell_a !== 8'd20) begin
      n_fail++; $display("FAIL wide_dwell: got %0d expected 20", dwell_a); end
    cyc(G, R, 1'b0);
    n_assert++; if ({s_order, s_timing, s_any} !== 3'b000) begin
      n_fail++; $display("FAIL sat_r2g_legal: got %b expected 000", {s_order, s_timing, s_any}); end
    n_assert++; if ({s_cycles, s_dwell_a} !== {16'd0, 3'd1}) begin
      n_fail++; $display("FAIL sat_first_green: got cycles %0d dwell %0d expected cycles 0 dwell 1", s_cycles, s_dwell_a); end
  endtask

  initial begin
    rst      = 1'b1;
    street_a = R;
    street_b = R;
    clr_err  = 1'b0;
    #2;
    test_reset();
    test_legal_sequence();
    test_conflict();
    test_order_code();
    test_timing();
    test_clear_and_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
